// File: rtl/fir_result_sink.sv
// fir_result_sink: captures one frame of filter output words into a RAM, then replays it in order
// over a valid/ready stream. Define FIR_SINK_OVF_FLAG_EN to add the ovf / drop_cnt overflow outputs.
//
// state     | meaning
// CAPTURE   | accepting in_valid strobes into RAM[wr_idx]
// FETCH     | RAM read address driven with rd_idx
// LOAD      | RAM read data moved into the output register
// PRESENT   | out_valid held until the downstream handshake
module fir_result_sink #(
  parameter int DATA_W    = 32,
  parameter int FRAME_LEN = 1000,
  parameter int ADDR_W    = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  input  logic              out_ready,
  output logic              frame_done,
  output logic              busy
`ifdef FIR_SINK_OVF_FLAG_EN
  ,
  output logic              ovf,
  output logic [15:0]       drop_cnt
`endif
);

  localparam logic [1:0] S_CAPTURE = 2'd0;
  localparam logic [1:0] S_FETCH   = 2'd1;
  localparam logic [1:0] S_LOAD    = 2'd2;
  localparam logic [1:0] S_PRESENT = 2'd3;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(FRAME_LEN - 1);

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] wr_idx_q, wr_idx_d;
  logic [ADDR_W-1:0] rd_idx_q, rd_idx_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;
  logic              out_last_q, out_last_d;
  logic              frame_done_q, frame_done_d;
  logic              in_ready_q;
  logic              busy_q;
  logic [DATA_W-1:0] ram_dout_q;
  logic [DATA_W-1:0] mem_q [FRAME_LEN];

  logic in_accept;
  logic out_accept;

  assign in_accept  = in_valid && (state_q == S_CAPTURE);
  assign out_accept = (state_q == S_PRESENT) && out_valid_q && out_ready;

  always_comb begin
    state_d      = state_q;
    wr_idx_d     = wr_idx_q;
    rd_idx_d     = rd_idx_q;
    out_data_d   = out_data_q;
    out_valid_d  = out_valid_q;
    out_last_d   = out_last_q;
    frame_done_d = 1'b0;
    case (state_q)
      S_CAPTURE: begin
        if (in_accept) begin
          if (wr_idx_q == LAST_IDX) begin
            wr_idx_d = '0;
            rd_idx_d = '0;
            state_d  = S_FETCH;
          end else begin
            wr_idx_d = wr_idx_q + 1'b1;
          end
        end
      end
      S_FETCH: begin
        state_d = S_LOAD;
      end
      S_LOAD: begin
        out_data_d  = ram_dout_q;
        out_valid_d = 1'b1;
        out_last_d  = (rd_idx_q == LAST_IDX);
        state_d     = S_PRESENT;
      end
      S_PRESENT: begin
        if (out_accept) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          if (out_last_q) begin
            frame_done_d = 1'b1;
            rd_idx_d     = '0;
            state_d      = S_CAPTURE;
          end else begin
            rd_idx_d = rd_idx_q + 1'b1;
            state_d  = S_FETCH;
          end
        end
      end
      default: begin
        state_d = S_CAPTURE;
      end
    endcase
  end

  // RAM has no reset; its contents are only read after a full frame has been written.
  always_ff @(posedge clk) begin
    if (in_accept) begin
      mem_q[wr_idx_q] <= in_data;
    end
    ram_dout_q <= mem_q[rd_idx_q];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_CAPTURE;
      wr_idx_q     <= '0;
      rd_idx_q     <= '0;
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      out_last_q   <= 1'b0;
      frame_done_q <= 1'b0;
      in_ready_q   <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_idx_q     <= wr_idx_d;
      rd_idx_q     <= rd_idx_d;
      out_data_q   <= out_data_d;
      out_valid_q  <= out_valid_d;
      out_last_q   <= out_last_d;
      frame_done_q <= frame_done_d;
      in_ready_q   <= (state_d == S_CAPTURE);
      busy_q       <= !((state_d == S_CAPTURE) && (wr_idx_d == '0));
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_last   = out_last_q;
  assign frame_done = frame_done_q;
  assign busy       = busy_q;

`ifdef FIR_SINK_OVF_FLAG_EN
  logic        in_discard;
  logic        ovf_q;
  logic [15:0] drop_cnt_q;

  assign in_discard = in_valid && (state_q != S_CAPTURE);

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q      <= 1'b0;
      drop_cnt_q <= '0;
    end else if (in_discard) begin
      ovf_q <= 1'b1;
      if (drop_cnt_q != 16'hFFFF) begin
        drop_cnt_q <= drop_cnt_q + 16'd1;
      end
    end
  end

  assign ovf      = ovf_q;
  assign drop_cnt = drop_cnt_q;
`endif

endmodule
